// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs NUM_BYTES bytes little-endian into one word on a valid/ready port.
// A flush request emits the partially filled word with byte enables.
module fifo_word_packer #(
   parameter int NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty_i,
   output logic                   fifo_rd_en_o,
   input  logic [7:0]             fifo_data_i,
   input  logic                   flush_i,
   output logic                   word_valid_o,
   input  logic                   word_ready_i,
   output logic [8*NUM_BYTES-1:0] word_data_o,
   output logic [NUM_BYTES-1:0]   word_be_o,
   output logic                   busy_o
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW:0] NB_W = (CW + 1)'(NUM_BYTES);

   typedef enum logic {
      S_FILL,
      S_OUT
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_pend;
   logic                  r_flush_req;
   logic [W-1:0]          r_buf;
   logic [W-1:0]          r_word;
   logic [NUM_BYTES-1:0]  r_be;
   logic                  r_valid;

   logic [CW:0]           w_fill_sum;
   logic [W-1:0]          w_buf_cap;
   logic [NUM_BYTES-1:0]  w_part_be;
   logic                  w_last_cap;
   logic                  w_flush_go;
   logic                  w_hs;

   // Bytes already held plus the one in flight bound how many more pops fit in the word.
   assign w_fill_sum   = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
   assign fifo_rd_en_o = (r_state == S_FILL) && !fifo_empty_i && !r_flush_req && (w_fill_sum < NB_W);

   assign w_last_cap = r_pend && (r_cnt == CW'(NUM_BYTES - 1));
   assign w_flush_go = (r_state == S_FILL) && r_flush_req && !r_pend;
   assign w_hs       = r_valid && word_ready_i;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_buf_cap = r_buf;
      w_part_be = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (r_pend && (r_cnt == CW'(k))) w_buf_cap[8*k +: 8] = fifo_data_i;
         if (r_cnt > CW'(k))              w_part_be[k] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; a later assignment to the same register overrides an earlier one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FILL;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_flush_req <= 1'b0;
         r_buf       <= '0;
         r_word      <= '0;
         r_be        <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_pend <= fifo_rd_en_o;
         if (flush_i) r_flush_req <= 1'b1;

         case (r_state)
            S_FILL: begin
               if (w_last_cap) begin
                  r_word  <= w_buf_cap;
                  r_be    <= '1;
                  r_valid <= 1'b1;
                  r_cnt   <= '0;
                  r_buf   <= '0;
                  r_state <= S_OUT;
               end else if (r_pend) begin
                  r_buf <= w_buf_cap;
                  r_cnt <= r_cnt + CW'(1);
               end else if (w_flush_go) begin
                  // A fresh flush arriving in the service cycle stays pending.
                  r_flush_req <= flush_i;
                  if (r_cnt != '0) begin
                     r_word  <= r_buf;
                     r_be    <= w_part_be;
                     r_valid <= 1'b1;
                     r_cnt   <= '0;
                     r_buf   <= '0;
                     r_state <= S_OUT;
                  end
               end
            end
            default: begin
               if (w_hs) begin
                  r_valid <= 1'b0;
                  r_be    <= '0;
                  r_state <= S_FILL;
               end
            end
         endcase
      end
   end

   assign word_valid_o = r_valid;
   assign word_data_o  = r_word;
   assign word_be_o    = r_be;
   assign busy_o       = (r_cnt != '0) || r_pend || r_valid || r_flush_req;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a byte FIFO model feeds the packer, a byte-list reference model
// predicts the word stream, and a monitor scoreboards every accepted word.
module tb_fifo_word_packer;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [NB-1:0] be;
   } word_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty_i;
   logic          fifo_rd_en_o;
   logic [7:0]    fifo_data_i = 8'h00;
   logic          flush_i = 1'b0;
   logic          word_valid_o;
   logic          word_ready_i = 1'b0;
   logic [W-1:0]  word_data_o;
   logic [NB-1:0] word_be_o;
   logic          busy_o;

   fifo_word_packer #(.NUM_BYTES(NB)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .fifo_data_i  (fifo_data_i),
      .flush_i      (flush_i),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .word_data_o  (word_data_o),
      .word_be_o    (word_be_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes accepted since the last word boundary, and the words they must form.
   logic [7:0] model_bytes[$];
   word_t      exp_q[$];

   function automatic void model_emit();
      word_t w;
      w = '0;
      foreach (model_bytes[i]) begin
         w.data[8*i +: 8] = model_bytes[i];
         w.be[i]          = 1'b1;
      end
      exp_q.push_back(w);
      model_bytes.delete();
   endfunction

   function automatic void model_push(input logic [7:0] b);
      model_bytes.push_back(b);
      if (model_bytes.size() == NB) model_emit();
   endfunction

   function automatic void model_flush();
      if (model_bytes.size() > 0) model_emit();
   endfunction

   // Depth-8 byte FIFO with one-cycle read latency; gating can force the empty flag high.
   logic [7:0] fifo_mem[8];
   int         fifo_count = 0;
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         nxt_count;
   logic       push_v = 1'b0;
   logic [7:0] push_d = 8'h00;
   logic       gate_hold = 1'b0;
   logic       gate_t = 1'b0;
   logic       toggle_en = 1'b0;
   int         ready_mode = 0;

   assign fifo_empty_i = (fifo_count == 0) || gate_hold || gate_t;

   always @(posedge clk) begin
      nxt_count = fifo_count;
      if (fifo_rd_en_o && fifo_count > 0) begin
         fifo_data_i <= fifo_mem[rd_ptr];
         rd_ptr      <= (rd_ptr + 1) % 8;
         nxt_count   = nxt_count - 1;
      end
      if (push_v && fifo_count < 8) begin
         fifo_mem[wr_ptr] <= push_d;
         wr_ptr           <= (wr_ptr + 1) % 8;
         nxt_count        = nxt_count + 1;
      end
      fifo_count <= nxt_count;
   end

   always @(negedge clk) gate_t = toggle_en ? ~gate_t : 1'b0;

   // Monitor: drives ready, scoreboards accepted words and checks protocol invariants.
   logic  prev_stall = 1'b0;
   word_t held;
   word_t got;
   word_t want;

   always @(negedge clk) begin
      case (ready_mode)
         0:       word_ready_i = 1'b0;
         1:       word_ready_i = 1'b1;
         default: word_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (fifo_rd_en_o) check("no_pop_when_empty", fifo_empty_i, 1'b0);
         if (word_valid_o) check("no_pop_in_out", fifo_rd_en_o, 1'b0);
         if (prev_stall) begin
            check("valid_held", word_valid_o, 1'b1);
            check("word_stable", {word_data_o, word_be_o}, held);
         end
         if (word_valid_o && word_ready_i) begin
            got = {word_data_o, word_be_o};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: actual=0x%0h required=none at %0t", got, $time);
            end else begin
               want = exp_q.pop_front();
               check("word_data", got.data, want.data);
               check("word_be", got.be, want.be);
            end
         end
         prev_stall = word_valid_o && !word_ready_i;
         held       = {word_data_o, word_be_o};
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int budget = 0;
      while (fifo_count >= 8 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("push_space", fifo_count < 8, 1'b1);
      push_v = 1'b1;
      push_d = b;
      model_push(b);
      @(negedge clk);
      push_v = 1'b0;
   endtask

   task automatic flush_pulse();
      flush_i = 1'b1;
      model_flush();
      @(negedge clk);
      flush_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int budget = 0;
      while (!(exp_q.size() == 0 && fifo_count == 0 && !busy_o && !push_v) && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      check(name, (exp_q.size() == 0) && (fifo_count == 0) && !busy_o, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rd_en", fifo_rd_en_o, 1'b0);
      check("rst_valid", word_valid_o, 1'b0);
      check("rst_data", word_data_o, '0);
      check("rst_be", word_be_o, '0);
      check("rst_busy", busy_o, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Two full words with the consumer stalled.
      ready_mode = 0;
      for (int i = 1; i <= 8; i++) push_byte(8'(8'h11 * i));
      check("t1_valid", word_valid_o, 1'b1);
      check("t1_data", word_data_o, 32'h44332211);
      check("t1_be", word_be_o, 4'hF);
      repeat (10) begin
         @(negedge clk);
         check("t2_fifo_hold", fifo_count, 4);
         check("t2_valid_hold", word_valid_o, 1'b1);
      end
      ready_mode = 1;
      wait_idle("t2_idle");

      // Partial word by flush, then a flush with nothing collected.
      push_byte(8'hA1);
      push_byte(8'hA2);
      repeat (4) @(negedge clk);
      flush_pulse();
      wait_idle("t3_idle");
      flush_pulse();
      check("t3_busy_flush_req", busy_o, 1'b1);
      wait_idle("t3_empty_flush_idle");

      // Flush in the same cycle as the pop of the third byte.
      gate_hold = 1'b1;
      push_byte(8'hB1);
      push_byte(8'hB2);
      push_byte(8'hB3);
      gate_hold = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("t4_pop_byte3", fifo_rd_en_o, 1'b1);
      flush_pulse();
      wait_idle("t4_idle");

      // Asynchronous reset with two bytes held and one in flight.
      gate_hold = 1'b1;
      push_byte(8'hC1);
      push_byte(8'hC2);
      push_byte(8'hC3);
      gate_hold = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("t5_busy_before", busy_o, 1'b1);
      rst = 1'b1;
      model_bytes.delete();
      #1;
      check("t5_rst_rd_en", fifo_rd_en_o, 1'b0);
      check("t5_rst_valid", word_valid_o, 1'b0);
      check("t5_rst_data", word_data_o, '0);
      check("t5_rst_be", word_be_o, '0);
      check("t5_rst_busy", busy_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NB; i++) push_byte(8'($urandom));
      wait_idle("t5_idle");

      // Random bytes with the FIFO empty flag toggling and a random consumer.
      toggle_en  = 1'b1;
      ready_mode = 2;
      for (int i = 0; i < 40; i++) push_byte(8'($urandom));
      toggle_en  = 1'b0;
      ready_mode = 1;
      wait_idle("t6_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
